// File: rtl/alu_wb_buffer.sv
// In-order completion buffer between the integer ALU and the shared writeback port.
// Holds completed ops until writeback accepts them and back-pressures the ALU when full.
module alu_wb_buffer #(
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int EXCEPTION_CODE_WIDTH = 4,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            alu_done_i,
  input  logic [XLEN-1:0]                 alu_result_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i,
  input  logic                            alu_exception_valid_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i,
  output logic                            alu_stall_o,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic                            wb_prf_we_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
  output logic                            wb_exception_valid_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o,
  output logic [$clog2(DEPTH):0]          occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]                 result;
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr;
    logic [ROB_INDEX_WIDTH-1:0]      rob_index;
    logic                            exc_valid;
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             new_entry;
  entry_t             head_entry;

  // Stall comes only from the registered count, so the ALU never sees a
  // combinational path from the writeback ready.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign alu_stall_o = full;
  assign occupancy_o = count;

  assign push = alu_done_i & ~full & ~flush;
  assign pop  = ~empty & wb_ready_i & ~flush;

  always_comb begin
    new_entry           = '0;
    new_entry.result    = alu_result_i;
    new_entry.rd_addr   = alu_rd_addr_i;
    new_entry.rob_index = alu_rob_index_i;
    new_entry.exc_valid = alu_exception_valid_i;
    new_entry.ecause    = alu_exception_valid_i ? alu_ecause_i : '0;
  end

  // Capture stage: entry written at tail on push
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain stage: head entry presented combinationally, zeroed when empty
  always_comb begin
    head_entry = '0;
    if (!empty) head_entry = mem[head];
  end

  assign wb_valid_o           = ~empty;
  assign wb_prf_we_o          = ~empty & ~head_entry.exc_valid;
  assign wb_rd_addr_o         = head_entry.rd_addr;
  assign wb_data_o            = head_entry.result;
  assign wb_rob_index_o       = head_entry.rob_index;
  assign wb_exception_valid_o = head_entry.exc_valid;
  assign wb_ecause_o          = head_entry.ecause;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed testbench for alu_wb_buffer: single op, fill/stall, concurrent
// push/pop, exceptions, flush and mid-operation reset.
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        alu_done_i;
  logic [63:0] alu_result_i;
  logic [5:0]  alu_rd_addr_i;
  logic [3:0]  alu_rob_index_i;
  logic        alu_exception_valid_i;
  logic [3:0]  alu_ecause_i;
  logic        alu_stall_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_prf_we_o;
  logic [5:0]  wb_rd_addr_o;
  logic [63:0] wb_data_o;
  logic [3:0]  wb_rob_index_o;
  logic        wb_exception_valid_o;
  logic [3:0]  wb_ecause_o;
  logic [2:0]  occupancy_o;

  int checks   = 0;
  int failures = 0;

  alu_wb_buffer dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .flush                (flush),
    .alu_done_i           (alu_done_i),
    .alu_result_i         (alu_result_i),
    .alu_rd_addr_i        (alu_rd_addr_i),
    .alu_rob_index_i      (alu_rob_index_i),
    .alu_exception_valid_i(alu_exception_valid_i),
    .alu_ecause_i         (alu_ecause_i),
    .alu_stall_o          (alu_stall_o),
    .wb_valid_o           (wb_valid_o),
    .wb_ready_i           (wb_ready_i),
    .wb_prf_we_o          (wb_prf_we_o),
    .wb_rd_addr_o         (wb_rd_addr_o),
    .wb_data_o            (wb_data_o),
    .wb_rob_index_o       (wb_rob_index_o),
    .wb_exception_valid_o (wb_exception_valid_o),
    .wb_ecause_o          (wb_ecause_o),
    .occupancy_o          (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic done, input logic [63:0] res, input logic [5:0] rd,
                     input logic [3:0] rob, input logic exc, input logic [3:0] ec);
    alu_done_i            = done;
    alu_result_i          = res;
    alu_rd_addr_i         = rd;
    alu_rob_index_i       = rob;
    alu_exception_valid_i = exc;
    alu_ecause_i          = ec;
  endtask

  // Structural invariants sampled mid-cycle while out of reset
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("occ_le_depth", 64'(occupancy_o <= 3'd4), 64'd1);
      chk("valid_vs_occ", 64'(wb_valid_o), 64'(occupancy_o != 3'd0));
    end
  end

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    wb_ready_i = 1'b0;
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    step();
    step();
    chk("rst_stall", 64'(alu_stall_o), 64'd0);
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_we", 64'(wb_prf_we_o), 64'd0);
    chk("rst_data", wb_data_o, 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    rstn = 1'b1;
    step();

    // Single op with latency 1
    wb_ready_i = 1'b1;
    alu(1'b1, 64'h1234, 6'd5, 4'd3, 1'b0, 4'd0);
    step();
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("single_valid", 64'(wb_valid_o), 64'd1);
    chk("single_we", 64'(wb_prf_we_o), 64'd1);
    chk("single_data", wb_data_o, 64'h1234);
    chk("single_rd", 64'(wb_rd_addr_o), 64'd5);
    chk("single_rob", 64'(wb_rob_index_o), 64'd3);
    chk("single_occ", 64'(occupancy_o), 64'd1);
    step();
    chk("single_gone", 64'(wb_valid_o), 64'd0);
    chk("single_occ0", 64'(occupancy_o), 64'd0);

    // Fill to full with writeback blocked
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_nostall", 64'(alu_stall_o), 64'd0);
      alu(1'b1, 64'h10 + 64'(i), 6'(i + 1), 4'(i), 1'b0, 4'd0);
      step();
    end
    chk("fill_stall", 64'(alu_stall_o), 64'd1);
    chk("fill_occ", 64'(occupancy_o), 64'd4);
    chk("fill_head", wb_data_o, 64'h10);
    alu(1'b1, 64'h14, 6'd9, 4'd4, 1'b0, 4'd0);
    step();
    chk("held_occ", 64'(occupancy_o), 64'd4);
    chk("held_stall", 64'(alu_stall_o), 64'd1);
    chk("held_head", wb_data_o, 64'h10);
    // Pop while full: push blocked this edge, stall clears after
    wb_ready_i = 1'b1;
    step();
    chk("bubble_occ", 64'(occupancy_o), 64'd3);
    chk("bubble_stall", 64'(alu_stall_o), 64'd0);
    chk("drain_11", wb_data_o, 64'h11);
    step();
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("drain_12", wb_data_o, 64'h12);
    chk("drain_occ3", 64'(occupancy_o), 64'd3);
    step();
    chk("drain_13", wb_data_o, 64'h13);
    chk("drain_occ2", 64'(occupancy_o), 64'd2);
    step();
    chk("drain_14", wb_data_o, 64'h14);
    chk("drain_rd14", 64'(wb_rd_addr_o), 64'd9);
    chk("drain_occ1", 64'(occupancy_o), 64'd1);
    step();
    chk("drain_empty", 64'(wb_valid_o), 64'd0);
    chk("drain_occ0", 64'(occupancy_o), 64'd0);

    // Concurrent push/pop at occupancy 2
    wb_ready_i = 1'b0;
    alu(1'b1, 64'h20, 6'd1, 4'd0, 1'b0, 4'd0);
    step();
    alu(1'b1, 64'h21, 6'd1, 4'd1, 1'b0, 4'd0);
    step();
    chk("cc_occ_start", 64'(occupancy_o), 64'd2);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alu(1'b1, 64'h22 + 64'(i), 6'd1, 4'(i + 2), 1'b0, 4'd0);
      step();
      chk("cc_occ", 64'(occupancy_o), 64'd2);
      chk("cc_head", wb_data_o, 64'h21 + 64'(i));
      chk("cc_stall", 64'(alu_stall_o), 64'd0);
    end
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    step();
    chk("cc_last", wb_data_o, 64'h27);
    step();
    chk("cc_empty", 64'(wb_valid_o), 64'd0);

    // Exception entry followed by a normal entry with a stray cause
    wb_ready_i = 1'b0;
    alu(1'b1, 64'h30, 6'd7, 4'd9, 1'b1, 4'd2);
    step();
    alu(1'b1, 64'h31, 6'd8, 4'd10, 1'b0, 4'd5);
    step();
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("exc_valid", 64'(wb_valid_o), 64'd1);
    chk("exc_we", 64'(wb_prf_we_o), 64'd0);
    chk("exc_flag", 64'(wb_exception_valid_o), 64'd1);
    chk("exc_cause", 64'(wb_ecause_o), 64'd2);
    chk("exc_rob", 64'(wb_rob_index_o), 64'd9);
    wb_ready_i = 1'b1;
    step();
    chk("noexc_data", wb_data_o, 64'h31);
    chk("noexc_we", 64'(wb_prf_we_o), 64'd1);
    chk("noexc_flag", 64'(wb_exception_valid_o), 64'd0);
    chk("noexc_cause", 64'(wb_ecause_o), 64'd0);
    step();
    chk("exc_empty", 64'(wb_valid_o), 64'd0);

    // Flush at occupancy 3 with push and pop in the same cycle
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu(1'b1, 64'h40 + 64'(i), 6'd2, 4'(i), 1'b0, 4'd0);
      step();
    end
    chk("fl_occ3", 64'(occupancy_o), 64'd3);
    flush = 1'b1;
    wb_ready_i = 1'b1;
    alu(1'b1, 64'h43, 6'd3, 4'd3, 1'b0, 4'd0);
    step();
    flush = 1'b0;
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_valid", 64'(wb_valid_o), 64'd0);
    chk("fl_stall", 64'(alu_stall_o), 64'd0);
    chk("fl_data", wb_data_o, 64'd0);
    step();
    chk("fl_no43", 64'(wb_valid_o), 64'd0);

    // Flush while full releases stall
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu(1'b1, 64'h50 + 64'(i), 6'd4, 4'(i), 1'b0, 4'd0);
      step();
    end
    chk("flf_stall", 64'(alu_stall_o), 64'd1);
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flf_unstall", 64'(alu_stall_o), 64'd0);
    chk("flf_occ", 64'(occupancy_o), 64'd0);

    // Reset mid-operation while full and stalled
    for (int i = 0; i < 4; i++) begin
      alu(1'b1, 64'h60 + 64'(i), 6'd6, 4'(i), 1'(i == 1), 4'd7);
      step();
    end
    chk("mr_stall", 64'(alu_stall_o), 64'd1);
    chk("mr_occ4", 64'(occupancy_o), 64'd4);
    rstn = 1'b0;
    flush = 1'b1;
    wb_ready_i = 1'b1;
    step();
    flush = 1'b0;
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("mr_stall0", 64'(alu_stall_o), 64'd0);
    chk("mr_valid", 64'(wb_valid_o), 64'd0);
    chk("mr_we", 64'(wb_prf_we_o), 64'd0);
    chk("mr_data", wb_data_o, 64'd0);
    chk("mr_rd", 64'(wb_rd_addr_o), 64'd0);
    chk("mr_rob", 64'(wb_rob_index_o), 64'd0);
    chk("mr_exc", 64'(wb_exception_valid_o), 64'd0);
    chk("mr_cause", 64'(wb_ecause_o), 64'd0);
    chk("mr_occ", 64'(occupancy_o), 64'd0);
    rstn = 1'b1;
    wb_ready_i = 1'b0;
    alu(1'b1, 64'h55, 6'd11, 4'd12, 1'b0, 4'd0);
    step();
    alu(1'b0, 64'h0, 6'd0, 4'd0, 1'b0, 4'd0);
    chk("post_valid", 64'(wb_valid_o), 64'd1);
    chk("post_data", wb_data_o, 64'h55);
    chk("post_rd", 64'(wb_rd_addr_o), 64'd11);
    chk("post_occ", 64'(occupancy_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Downstream of the integer ALU.
- Captures each completed ALU op (result, destination physical register, ROB index, exception) into a small in-order FIFO.
- Drains entries to the shared writeback port, which feeds the physical register file write and ROB completion, using a valid/ready handshake.
- Drives the ALU's stall input so that no completed op is ever dropped or duplicated.

Parameters:
- XLEN, 64, datapath width of result.
- PHY_REG_ADDR_WIDTH, 6, physical register address width.
- ROB_INDEX_WIDTH, 4, ROB index width.
- EXCEPTION_CODE_WIDTH, 4, exception cause width.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; discards all buffered entries.
- alu_done_i  in  1  ALU output register holds a valid completed op.
- alu_result_i  in  XLEN  ALU result.
- alu_rd_addr_i  in  PHY_REG_ADDR_WIDTH  destination physical register.
- alu_rob_index_i  in  ROB_INDEX_WIDTH  ROB entry of the op.
- alu_exception_valid_i  in  1  op raised an exception.
- alu_ecause_i  in  EXCEPTION_CODE_WIDTH  exception cause.
- alu_stall_o  out  1  stall to ALU; ALU output registers hold while high.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback port accepts head this cycle.
- wb_prf_we_o  out  1  register-file write enable (wb_valid_o & ~head exception).
- wb_rd_addr_o  out  PHY_REG_ADDR_WIDTH  head destination.
- wb_data_o  out  XLEN  head result.
- wb_rob_index_o  out  ROB_INDEX_WIDTH  head ROB index.
- wb_exception_valid_o  out  1  head exception flag.
- wb_ecause_o  out  EXCEPTION_CODE_WIDTH  head cause; 0 when no exception.
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage and pointers:
  - Circular FIFO with head/tail pointers of $clog2(DEPTH) bits, wrapping naturally, plus a count register of $clog2(DEPTH)+1 bits.
  - All state updates on posedge clk.
- Handshake definitions:
  - push = alu_done_i & ~alu_stall_o & ~flush.
  - pop = wb_valid_o & wb_ready_i & ~flush.
- Stall:
  - alu_stall_o = (count == DEPTH). It is decoded from registered count only, with no combinational path from wb_ready_i or alu_done_i.
  - While stalled, the ALU output is held and re-presented; it is captured exactly once, on the first edge where alu_stall_o is low.
- Latency: a pushed entry appears on wb_* the cycle after the push edge. There is no same-cycle bypass.
- Outputs:
  - wb_* outputs are driven from the head entry (FIFO read is combinational).
  - When empty: wb_valid_o=0, wb_prf_we_o=0; data fields are don't-care but driven to 0.
  - Exception entry: wb_prf_we_o=0 while wb_valid_o=1. ROB completion still occurs with wb_ecause_o.
  - wb_ecause_o is stored as alu_ecause_i when alu_exception_valid_i=1, and as 0 otherwise.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - Legal at any non-full count, including count 1 (head leaves while the new entry lands at tail).
- Full with pop:
  - The pop frees a slot, but push is blocked that cycle because the stall is already high.
  - Stall deasserts the next cycle. The one-cycle bubble is accepted behaviour.
- Empty: pop cannot occur; wb_ready_i is ignored.
- Flush:
  - Head, tail and count go to 0 at the next edge. All entries are discarded, including any push or pop in the same cycle.
  - alu_stall_o is low the cycle after flush.
  - Flush has priority over push and pop.
- Reset (rstn=0 at an edge), also mid-operation:
  - Pointers and count go to 0 and entry storage is cleared.
  - Reset values: alu_stall_o=0, wb_valid_o=0, wb_prf_we_o=0, all wb_* data fields 0, occupancy_o=0.
  - Reset dominates flush.
- Ordering: strict in-order; entries leave in push order.
- Overflow/underflow are impossible by construction. The bench asserts count never exceeds DEPTH and no pop occurs when empty.

Test Plan:
- Single op: alu_done_i=1 one cycle, result 0x1234, rd 5, rob 3, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_prf_we_o=1, data 0x1234, rd 5, rob 3. Following cycle wb_valid_o=0.
- Fill: wb_ready_i=0, 4 back-to-back pushes (0x10..0x13) -> alu_stall_o=1 after 4th edge, occupancy_o=4.
  - Held 5th op (0x14) is not captured.
  - Raise wb_ready_i -> drains 0x10,0x11,0x12,0x13,0x14 in order, each exactly once.
- Concurrent push/pop at occupancy 2 for 6 cycles with wb_ready_i=1 -> occupancy_o stays 2, outputs in order, no stall.
- Exception: push with exception_valid=1, ecause 2 -> wb_valid_o=1, wb_prf_we_o=0, wb_exception_valid_o=1, wb_ecause_o=2.
  - Next non-exception entry shows wb_ecause_o=0.
- Flush at occupancy 3 with simultaneous push and wb_ready_i=1 -> next cycle occupancy_o=0, wb_valid_o=0, alu_stall_o=0. The flushed-cycle op never appears.
- Reset mid-operation: rstn=0 at occupancy 4 with stall high -> next cycle all outputs at reset values. After release, first push appears with latency 1.
